// File: rtl/bullet_pool_pkg.sv
// Shared types and helpers for the bullet pool: slot state encoding and the
// saturating subtract used to place idle bullets relative to the ship.
package bullet_pkg;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_t;

  localparam int POS_WIDTH_DEF = 10;
  typedef logic [POS_WIDTH_DEF-1:0] pos_t;

  // Idle bullet y clamps at the top edge instead of wrapping when the ship is near y=0.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Bundle between the ship controller / fire decode (master) and the bullet pool (slave).
interface bullet_pool_if #(
  parameter int BulletCount = 4,
  parameter int PosWidth    = 10
);
  localparam int CntW = $clog2(BulletCount + 1);

  logic                                 fire_i;
  logic [PosWidth-1:0]                  ship_x_i;
  logic [PosWidth-1:0]                  ship_y_i;
  logic [BulletCount-1:0]               hit_i;
  logic [BulletCount-1:0][PosWidth-1:0] x_pos_o;
  logic [BulletCount-1:0][PosWidth-1:0] y_pos_o;
  logic [BulletCount-1:0]               active_o;
  logic                                 fire_ack_o;
  logic [CntW-1:0]                      active_count_o;

  modport master (
    output fire_i, ship_x_i, ship_y_i, hit_i,
    input  x_pos_o, y_pos_o, active_o, fire_ack_o, active_count_o
  );

  modport slave (
    input  fire_i, ship_x_i, ship_y_i, hit_i,
    output x_pos_o, y_pos_o, active_o, fire_ack_o, active_count_o
  );
endinterface

// File: rtl/bullet_pool_slot.sv
// One bullet slot: idle slots track the ship, flying slots climb Speed px per
// frame with x frozen, and retire on a hit or when reaching the top band.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int PosWidth = 10,
  parameter int Speed    = 5,
  parameter int TopLimit = 0
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                launch_i,
  input  logic                hit_i,
  input  logic [PosWidth-1:0] ship_x_i,
  input  logic [PosWidth-1:0] home_y_i,
  output logic [PosWidth-1:0] x_pos_o,
  output logic [PosWidth-1:0] y_pos_o,
  output logic                active_o,
  output logic                retiring_o
);
  localparam logic [31:0]         RetireY = 32'(TopLimit + Speed);
  localparam logic [PosWidth-1:0] Step    = PosWidth'(Speed);

  slot_state_t         state_q, state_d;
  logic [PosWidth-1:0] x_q, x_d, y_q, y_d;
  logic                below_top;

  assign below_top  = 32'(y_q) < RetireY;
  assign retiring_o = (state_q == SLOT_FLYING) && (hit_i || below_top);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      SLOT_IDLE: begin
        x_d = ship_x_i;
        y_d = home_y_i;
        if (launch_i) state_d = SLOT_FLYING;
      end
      SLOT_FLYING: begin
        // Retire reloads the ship-relative position so the slot is ready to relaunch.
        if (retiring_o) begin
          state_d = SLOT_IDLE;
          x_d     = ship_x_i;
          y_d     = home_y_i;
        end else begin
          y_d = y_q - Step;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= SLOT_IDLE;
      x_q     <= ship_x_i;
      y_q     <= home_y_i;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign x_pos_o  = x_q;
  assign y_pos_o  = y_q;
  assign active_o = (state_q == SLOT_FLYING);
endmodule

// File: rtl/bullet_pool.sv
// Player bullet pool: lowest-free-slot allocation, launch cooldown and flying count.
// Define BULLET_POOL_FIRE_QUEUE_EN to hold one unserved fire request until it can launch.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int BulletCount    = 4,
  parameter int PosWidth       = 10,
  parameter int Speed          = 5,
  parameter int YOffset        = 16,
  parameter int TopLimit       = 0,
  parameter int CooldownFrames = 8
) (
  input  logic           frame_clk_i,
  input  logic           reset_i,
  bullet_pool_if.slave   bus
);
  localparam int             CntW   = $clog2(BulletCount + 1);
  localparam int             CdW    = (CooldownFrames > 0) ? $clog2(CooldownFrames + 1) : 1;
  localparam logic [CdW-1:0] CdLoad = CdW'(CooldownFrames);

  logic [PosWidth-1:0]    home_y;
  logic [BulletCount-1:0] active, retiring, eligible, launch_vec, active_next;
  logic                   request, go, launch_any, found;
  logic [CdW-1:0]         cooldown_q, cooldown_d;
  logic                   fire_ack_q, fire_ack_d;
  logic [CntW-1:0]        count_q, count_d;

  assign home_y = PosWidth'(sat_sub(32'(bus.ship_y_i), 32'(YOffset)));

`ifdef BULLET_POOL_FIRE_QUEUE_EN
  logic pending_q, pending_d;

  assign request = bus.fire_i | pending_q;

  always_comb begin
    pending_d = pending_q;
    if (launch_any)      pending_d = 1'b0;
    else if (bus.fire_i) pending_d = 1'b1;
  end

  always_ff @(posedge frame_clk_i) begin
    if (reset_i) pending_q <= 1'b0;
    else         pending_q <= pending_d;
  end
`else
  assign request = bus.fire_i;
`endif

  // A slot retiring this edge is still FLYING, so it only becomes eligible next edge.
  assign eligible = ~active & ~retiring;
  assign go       = request && (cooldown_q == '0);

  always_comb begin
    launch_vec = '0;
    found      = 1'b0;
    for (int i = 0; i < BulletCount; i++) begin
      if (eligible[i] && !found) begin
        launch_vec[i] = go;
        found         = 1'b1;
      end
    end
  end

  assign launch_any = |launch_vec;

  generate
    for (genvar gi = 0; gi < BulletCount; gi++) begin : g_slot
      bullet_slot #(
        .PosWidth (PosWidth),
        .Speed    (Speed),
        .TopLimit (TopLimit)
      ) u_slot (
        .clk        (frame_clk_i),
        .srst       (reset_i),
        .launch_i   (launch_vec[gi]),
        .hit_i      (bus.hit_i[gi]),
        .ship_x_i   (bus.ship_x_i),
        .home_y_i   (home_y),
        .x_pos_o    (bus.x_pos_o[gi]),
        .y_pos_o    (bus.y_pos_o[gi]),
        .active_o   (active[gi]),
        .retiring_o (retiring[gi])
      );
      assign active_next[gi] = (active[gi] & ~retiring[gi]) | launch_vec[gi];
    end
  endgenerate

  always_comb begin
    count_d    = '0;
    for (int i = 0; i < BulletCount; i++) begin
      count_d = count_d + CntW'(active_next[i]);
    end
    fire_ack_d = launch_any;
    cooldown_d = cooldown_q;
    if (launch_any)              cooldown_d = CdLoad;
    else if (cooldown_q != '0)   cooldown_d = cooldown_q - CdW'(1);
  end

  always_ff @(posedge frame_clk_i) begin
    if (reset_i) begin
      cooldown_q <= '0;
      fire_ack_q <= 1'b0;
      count_q    <= '0;
    end else begin
      cooldown_q <= cooldown_d;
      fire_ack_q <= fire_ack_d;
      count_q    <= count_d;
    end
  end

  assign bus.active_o       = active;
  assign bus.fire_ack_o     = fire_ack_q;
  assign bus.active_count_o = count_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool (4 slots, Speed 5, YOffset 16, TopLimit 0, cooldown 8).
module tb_bullet_pool;
  import bullet_pkg::*;

  localparam int N = 4;
  localparam int W = 10;
`ifdef BULLET_POOL_FIRE_QUEUE_EN
  localparam bit QueueEn = 1'b1;
`else
  localparam bit QueueEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  bullet_pool_if #(.BulletCount(N), .PosWidth(W)) bus ();

  bullet_pool #(
    .BulletCount(N), .PosWidth(W), .Speed(5), .YOffset(16),
    .TopLimit(0), .CooldownFrames(8)
  ) dut (
    .frame_clk_i (clk),
    .reset_i     (rst),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.fire_i = 1'b0; bus.hit_i = '0;
    bus.ship_x_i = 10'd320; bus.ship_y_i = 10'd400;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.fire_i = 1'b1; bus.hit_i = '0;
    bus.ship_x_i = 10'd320; bus.ship_y_i = 10'd400;
    step(); step();
    checks++; if (bus.active_o !== 4'b0000) begin fails++; $display("FAIL reset_active: got %b expected 0000", bus.active_o); end
    for (int i = 0; i < N; i++) begin
      checks++; if (bus.x_pos_o[i] !== 10'd320) begin fails++; $display("FAIL reset_x%0d: got %0d expected 320", i, bus.x_pos_o[i]); end
      checks++; if (bus.y_pos_o[i] !== 10'd384) begin fails++; $display("FAIL reset_y%0d: got %0d expected 384", i, bus.y_pos_o[i]); end
    end
    checks++; if (bus.fire_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", bus.fire_ack_o); end
    checks++; if (bus.active_count_o !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.active_count_o); end
    rst = 1'b0; bus.fire_i = 1'b0; bus.ship_y_i = 10'd10;
    step();
    checks++; if (bus.y_pos_o[0] !== 10'd0) begin fails++; $display("FAIL home_saturate: got %0d expected 0", bus.y_pos_o[0]); end
    bus.ship_y_i = 10'd400;
    step();
    checks++; if (bus.y_pos_o[0] !== 10'd384) begin fails++; $display("FAIL home_restore: got %0d expected 384", bus.y_pos_o[0]); end
    $display("test_reset done: active=%b count=%0d", bus.active_o, bus.active_count_o);
  endtask

  task automatic test_fire_and_hit();
    do_reset();
    bus.fire_i = 1'b1;
    step();
    checks++; if (bus.active_o !== 4'b0001) begin fails++; $display("FAIL fire_active: got %b expected 0001", bus.active_o); end
    checks++; if (bus.y_pos_o[0] !== 10'd384) begin fails++; $display("FAIL fire_y0: got %0d expected 384", bus.y_pos_o[0]); end
    checks++; if (bus.fire_ack_o !== 1'b1) begin fails++; $display("FAIL fire_ack: got %b expected 1", bus.fire_ack_o); end
    checks++; if (bus.active_count_o !== 3'd1) begin fails++; $display("FAIL fire_count: got %0d expected 1", bus.active_count_o); end
    bus.fire_i = 1'b0; bus.ship_x_i = 10'd100;
    step();
    checks++; if (bus.y_pos_o[0] !== 10'd379) begin fails++; $display("FAIL fly_y1: got %0d expected 379", bus.y_pos_o[0]); end
    checks++; if (bus.x_pos_o[0] !== 10'd320) begin fails++; $display("FAIL fly_x_frozen: got %0d expected 320", bus.x_pos_o[0]); end
    checks++; if (bus.x_pos_o[1] !== 10'd100) begin fails++; $display("FAIL idle_follow_x: got %0d expected 100", bus.x_pos_o[1]); end
    checks++; if (bus.fire_ack_o !== 1'b0) begin fails++; $display("FAIL ack_one_frame: got %b expected 0", bus.fire_ack_o); end
    step();
    checks++; if (bus.y_pos_o[0] !== 10'd374) begin fails++; $display("FAIL fly_y2: got %0d expected 374", bus.y_pos_o[0]); end
    $display("test_fire: slot0 at (%0d,%0d)", bus.x_pos_o[0], bus.y_pos_o[0]);
    bus.hit_i = 4'b0010;
    step();
    checks++; if (bus.active_o !== 4'b0001) begin fails++; $display("FAIL hit_idle: got %b expected 0001", bus.active_o); end
    checks++; if (bus.y_pos_o[0] !== 10'd369) begin fails++; $display("FAIL hit_idle_y0: got %0d expected 369", bus.y_pos_o[0]); end
    bus.hit_i = 4'b0001;
    step();
    bus.hit_i = '0;
    checks++; if (bus.active_o !== 4'b0000) begin fails++; $display("FAIL hit_retire: got %b expected 0000", bus.active_o); end
    checks++; if (bus.x_pos_o[0] !== 10'd100 || bus.y_pos_o[0] !== 10'd384) begin fails++; $display("FAIL hit_reload: got (%0d,%0d) expected (100,384)", bus.x_pos_o[0], bus.y_pos_o[0]); end
    checks++; if (bus.active_count_o !== 3'd0) begin fails++; $display("FAIL hit_count: got %0d expected 0", bus.active_count_o); end
    $display("test_hit done: active=%b", bus.active_o);
  endtask

  task automatic test_cooldown_full();
    logic       exp_ack;
    logic [3:0] exp_act;
    do_reset();
    for (int e = 0; e <= 80; e++) begin
      bus.fire_i = (e <= 27) || (e == 36);
      step();
      exp_ack = (e == 0) || (e == 9) || (e == 18) || (e == 27) || (QueueEn && e == 78);
      checks++; if (bus.fire_ack_o !== exp_ack) begin fails++; $display("FAIL cd_ack_e%0d: got %b expected %b", e, bus.fire_ack_o, exp_ack); end
      if (bus.fire_ack_o) $display("launch at edge %0d: active=%b", e, bus.active_o);
      if (e == 9) begin
        checks++; if (bus.active_o !== 4'b0011) begin fails++; $display("FAIL cd_slot1: got %b expected 0011", bus.active_o); end
      end
      if (e == 36) begin
        checks++; if (bus.active_o !== 4'b1111 || bus.active_count_o !== 3'd4) begin fails++; $display("FAIL full_state: got %b/%0d expected 1111/4", bus.active_o, bus.active_count_o); end
      end
      if (e == 76) begin
        checks++; if (bus.y_pos_o[0] !== 10'd4) begin fails++; $display("FAIL cd_y76: got %0d expected 4", bus.y_pos_o[0]); end
      end
      if (e == 77) begin
        checks++; if (bus.active_o !== 4'b1110) begin fails++; $display("FAIL top_retire: got %b expected 1110", bus.active_o); end
      end
      if (e == 78) begin
        exp_act = QueueEn ? 4'b1111 : 4'b1110;
        checks++; if (bus.active_o !== exp_act) begin fails++; $display("FAIL queued_launch: got %b expected %b", bus.active_o, exp_act); end
      end
    end
    bus.fire_i = 1'b0;
  endtask

  task automatic test_retire_relaunch();
    do_reset();
    bus.fire_i = 1'b1;
    step();
    bus.fire_i = 1'b0;
    for (int e = 1; e <= 76; e++) step();
    checks++; if (bus.y_pos_o[0] !== 10'd4 || bus.active_o !== 4'b0001) begin fails++; $display("FAIL pre_retire: got y=%0d act=%b expected y=4 act=0001", bus.y_pos_o[0], bus.active_o); end
    bus.fire_i = 1'b1;
    step();
    bus.fire_i = 1'b0;
    checks++; if (bus.active_o !== 4'b0010) begin fails++; $display("FAIL retire_relaunch: got %b expected 0010", bus.active_o); end
    checks++; if (bus.fire_ack_o !== 1'b1) begin fails++; $display("FAIL relaunch_ack: got %b expected 1", bus.fire_ack_o); end
    checks++; if (bus.y_pos_o[0] !== 10'd384 || bus.y_pos_o[1] !== 10'd384) begin fails++; $display("FAIL relaunch_y: got %0d/%0d expected 384/384", bus.y_pos_o[0], bus.y_pos_o[1]); end
    checks++; if (bus.active_count_o !== 3'd1) begin fails++; $display("FAIL relaunch_count: got %0d expected 1", bus.active_count_o); end
    $display("test_retire_relaunch done: active=%b", bus.active_o);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.fire_i = 1'b1;
    for (int e = 0; e <= 18; e++) step();
    checks++; if (bus.active_count_o !== 3'd3) begin fails++; $display("FAIL mid_count: got %0d expected 3", bus.active_count_o); end
    rst = 1'b1;
    step();
    checks++; if (bus.active_o !== 4'b0000 || bus.fire_ack_o !== 1'b0) begin fails++; $display("FAIL mid_reset: got act=%b ack=%b expected 0000/0", bus.active_o, bus.fire_ack_o); end
    checks++; if (bus.active_count_o !== 3'd0) begin fails++; $display("FAIL mid_reset_count: got %0d expected 0", bus.active_count_o); end
    checks++; if (bus.y_pos_o[2] !== 10'd384) begin fails++; $display("FAIL mid_reset_y2: got %0d expected 384", bus.y_pos_o[2]); end
    rst = 1'b0;
    step();
    bus.fire_i = 1'b0;
    checks++; if (bus.active_o !== 4'b0001 || bus.fire_ack_o !== 1'b1) begin fails++; $display("FAIL post_reset_fire: got act=%b ack=%b expected 0001/1", bus.active_o, bus.fire_ack_o); end
    $display("test_reset_midflight done: active=%b", bus.active_o);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b1; bus.fire_i = 1'b0; bus.hit_i = '0;
    bus.ship_x_i = 10'd320; bus.ship_y_i = 10'd400;
    test_reset();
    test_fire_and_hit();
    test_cooldown_full();
    test_retire_relaunch();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
